omem_arbiter: RTL and testbench

Owns the single output-memory (OMEM) port behind the MAC array. Shares it between four users:
- a clear sweep requested by the tile controller;
- OutputStage row writes, which cannot stall and so are buffered in a FIFO;
- WBuffer accumulate-store bursts;
- host readout.

It drives the OMEM bus and reports bus ownership (OMSRC) and busy status back to the tile controller.

---
 rtl/omem_arbiter.sv | 127 ++++++++++++
 tb/tb_omem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/omem_arbiter.sv
// omem_arbiter: shares the single OMEM port between the clear sweep, the OutputStage FIFO,
// WBuffer store bursts and host reads; all OMEM port signals are registered.
module omem_arbiter #(
    parameter int DW     = 80,
    parameter int FD     = 8,
    parameter int STARVE = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLR_REQ,
    output logic          CLR_BUSY,
    input  logic          OS_WE,
    input  logic [3:0]    OS_ADDR,
    input  logic [DW-1:0] OS_DATA,
    output logic          OS_OVF,
    input  logic          WB_REQ,
    input  logic          WB_WE,
    input  logic [3:0]    WB_ADDR,
    input  logic [DW-1:0] WB_DATA,
    input  logic          WB_LAST,
    output logic          WB_GNT,
    input  logic          HOST_RE,
    input  logic [3:0]    HOST_ADDR,
    output logic          HOST_GNT,
    output logic          HOST_RVALID,
    output logic [DW-1:0] HOST_RDATA,
    output logic          OM_WE,
    output logic          OM_RE,
    output logic [3:0]    OM_ADDR,
    output logic [DW-1:0] OM_WDATA,
    input  logic [DW-1:0] OM_RDATA,
    output logic          OMSRC,
    output logic          ARB_IDLE
);
    localparam int AW = $clog2(FD);
    localparam int SW = $clog2(STARVE + 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_WB} state_t;

    state_t            state, state_n;
    logic [3:0]        sweep;
    logic [SW-1:0]     starve;
    logic [DW+3:0]     mem [FD];
    logic [DW+3:0]     head;
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       cnt;
    logic              idle, clearing, fifo_ne, full, starved;
    logic              clr_go, wb_go, pop, push, host_go, wb_wr;
    logic              om_we_n;
    logic [3:0]        om_addr_n;
    logic [DW-1:0]     om_wdata_n;

    assign idle     = state == S_IDLE;
    assign clearing = state == S_CLEAR;
    assign fifo_ne  = cnt != '0;
    assign full     = cnt == (AW+1)'(FD);
    assign head     = mem[rp];
    assign starved  = WB_REQ && starve >= SW'(STARVE);
    // Single priority chain: clear, starved WB, FIFO, WB, host
    assign clr_go   = idle && CLR_REQ;
    assign wb_go    = idle && !CLR_REQ && WB_REQ && (starved || !fifo_ne);
    assign pop      = idle && !CLR_REQ && !starved && fifo_ne;
    assign host_go  = idle && !CLR_REQ && !WB_REQ && !fifo_ne && HOST_RE;
    assign push     = OS_WE && (!full || pop);
    assign wb_wr    = WB_GNT && WB_WE;
    assign HOST_RDATA = OM_RDATA;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = idle ? (clr_go ? S_CLEAR : wb_go ? S_WB : S_IDLE)
                : clearing ? (sweep == 4'hF ? S_IDLE : S_CLEAR)
                : ((WB_WE && WB_LAST) || !WB_REQ) ? S_IDLE : S_WB;
    end

    always_comb begin
        CLR_BUSY = clearing;
        WB_GNT   = state == S_WB;
        OMSRC    = state == S_WB;
        HOST_GNT = host_go;
        ARB_IDLE = idle && !fifo_ne && !WB_REQ && !HOST_RE && !CLR_REQ;
    end

    always_comb begin
        om_we_n    = pop || clearing || wb_wr;
        om_addr_n  = pop ? head[DW +: 4] : clearing ? sweep : wb_wr ? WB_ADDR : host_go ? HOST_ADDR : 4'd0;
        om_wdata_n = pop ? head[DW-1:0] : wb_wr ? WB_DATA : '0;
    end

    always_ff @(posedge CLK) begin
        if (push)
            mem[wp] <= {OS_ADDR, OS_DATA};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sweep       <= '0;
            starve      <= '0;
            wp          <= '0;
            rp          <= '0;
            cnt         <= '0;
            OS_OVF      <= 1'b0;
            OM_WE       <= 1'b0;
            OM_RE       <= 1'b0;
            OM_ADDR     <= '0;
            OM_WDATA    <= '0;
            HOST_RVALID <= 1'b0;
        end else begin
            sweep       <= clearing ? sweep + 4'd1 : 4'd0;
            starve      <= (!WB_REQ || wb_go) ? '0 : (idle && starve != SW'(STARVE)) ? starve + 1'b1 : starve;
            wp          <= push ? wp + 1'b1 : wp;
            rp          <= pop ? rp + 1'b1 : rp;
            cnt         <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            OS_OVF      <= (OS_OVF && !CLR_REQ) || (OS_WE && !push);
            OM_WE       <= om_we_n;
            OM_RE       <= host_go;
            OM_ADDR     <= om_addr_n;
            OM_WDATA    <= om_wdata_n;
            HOST_RVALID <= OM_RE;
        end
    end
endmodule

// File: tb/tb_omem_arbiter.sv
// tb_omem_arbiter: directed stimulus with queued expectations; one monitor process owns all checking.
module tb_omem_arbiter;
    localparam int DW = 80;
    localparam int I_CLR = 0, I_IDLE = 1, I_WBG = 2, I_HG = 3, I_OVF = 4, I_SRC = 5;
    localparam int I_RV = 6, I_WE = 7, I_RE = 8, I_ADDR = 9, I_WD = 10, I_RD = 11;

    logic          CLK = 1'b0, RST;
    logic          CLR_REQ, CLR_BUSY, OS_WE, OS_OVF, WB_REQ, WB_WE, WB_LAST, WB_GNT;
    logic [3:0]    OS_ADDR, WB_ADDR, HOST_ADDR, OM_ADDR;
    logic [DW-1:0] OS_DATA, WB_DATA, HOST_RDATA, OM_WDATA, OM_RDATA;
    logic          HOST_RE, HOST_GNT, HOST_RVALID, OM_WE, OM_RE, OMSRC, ARB_IDLE;

    omem_arbiter #(.DW(DW), .FD(8), .STARVE(8)) dut (
        .CLK(CLK), .RST(RST), .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY),
        .OS_WE(OS_WE), .OS_ADDR(OS_ADDR), .OS_DATA(OS_DATA), .OS_OVF(OS_OVF),
        .WB_REQ(WB_REQ), .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_LAST(WB_LAST), .WB_GNT(WB_GNT),
        .HOST_RE(HOST_RE), .HOST_ADDR(HOST_ADDR), .HOST_GNT(HOST_GNT), .HOST_RVALID(HOST_RVALID), .HOST_RDATA(HOST_RDATA),
        .OM_WE(OM_WE), .OM_RE(OM_RE), .OM_ADDR(OM_ADDR), .OM_WDATA(OM_WDATA), .OM_RDATA(OM_RDATA),
        .OMSRC(OMSRC), .ARB_IDLE(ARB_IDLE)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] omem [16];
    always @(posedge CLK) begin
        if (OM_WE) omem[OM_ADDR] <= OM_WDATA;
        if (OM_RE) OM_RDATA <= omem[OM_ADDR];
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { logic re; logic [3:0] addr; logic [DW-1:0] data; } op_t;
    typedef struct { int cyc; int id; logic [DW-1:0] val; } st_t;
    op_t           om_q[$];
    logic [DW-1:0] rd_q[$];
    st_t           st_q[$];
    op_t           e;
    logic [DW-1:0] rd_e;
    int            errors = 0, checks = 0;
    logic          done = 1'b0;
    string         names[12] = '{"CLR_BUSY", "ARB_IDLE", "WB_GNT", "HOST_GNT", "OS_OVF", "OMSRC",
                                 "HOST_RVALID", "OM_WE", "OM_RE", "OM_ADDR", "OM_WDATA", "HOST_RDATA"};

    function automatic logic [DW-1:0] sig(int id);
        case (id)
            I_CLR:  return DW'(CLR_BUSY);
            I_IDLE: return DW'(ARB_IDLE);
            I_WBG:  return DW'(WB_GNT);
            I_HG:   return DW'(HOST_GNT);
            I_OVF:  return DW'(OS_OVF);
            I_SRC:  return DW'(OMSRC);
            I_RV:   return DW'(HOST_RVALID);
            I_WE:   return DW'(OM_WE);
            I_RE:   return DW'(OM_RE);
            I_ADDR: return DW'(OM_ADDR);
            I_WD:   return OM_WDATA;
            default: return HOST_RDATA;
        endcase
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic exp_st(int dc, int id, logic [DW-1:0] v);
        st_q.push_back('{cyc + dc, id, v});
    endtask

    task automatic exp_wr(int a, int d);
        om_q.push_back('{1'b0, 4'(a), DW'(d)});
    endtask

    task automatic exp_sweep(int last);
        for (int i = 0; i <= last; i++) exp_wr(i, 0);
    endtask

    // Monitor: pops the scoreboard on every OMEM operation / read return, and checks timed status points
    initial begin
        forever begin
            @(negedge CLK);
            if (OM_WE === 1'b1 || OM_RE === 1'b1) begin
                checks++;
                if (om_q.size() == 0) begin
                    errors++;
                    $display("FAIL om_op@%0d: got we=%b re=%b addr=%0d data=%h, required no operation", cyc, OM_WE, OM_RE, OM_ADDR, OM_WDATA);
                end else begin
                    e = om_q.pop_front();
                    if (OM_RE !== e.re || OM_WE !== !e.re || OM_ADDR !== e.addr || (!e.re && OM_WDATA !== e.data)) begin
                        errors++;
                        $display("FAIL om_op@%0d: got we=%b re=%b addr=%0d data=%h, required re=%b addr=%0d data=%h", cyc, OM_WE, OM_RE, OM_ADDR, OM_WDATA, e.re, e.addr, e.data);
                    end
                end
            end
            if (HOST_RVALID === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL host_rdata@%0d: got unexpected HOST_RVALID data=%h", cyc, HOST_RDATA);
                end else begin
                    rd_e = rd_q.pop_front();
                    if (HOST_RDATA !== rd_e) begin
                        errors++;
                        $display("FAIL host_rdata@%0d: got %h, required %h", cyc, HOST_RDATA, rd_e);
                    end
                end
            end
            for (int i = st_q.size() - 1; i >= 0; i--) begin
                if (st_q[i].cyc == cyc) begin
                    checks++;
                    if (sig(st_q[i].id) !== st_q[i].val) begin
                        errors++;
                        $display("FAIL %s@%0d: got %h, required %h", names[st_q[i].id], cyc, sig(st_q[i].id), st_q[i].val);
                    end
                    st_q.delete(i);
                end
            end
            if (done || cyc > 5000) begin
                checks++;
                if (!done || om_q.size() != 0 || rd_q.size() != 0 || st_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: done=%b pending ops=%0d reads=%0d status=%0d, required all 0", done, om_q.size(), rd_q.size(), st_q.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    int k;
    initial begin
        RST = 1'b1; CLR_REQ = 0; OS_WE = 0; OS_ADDR = 0; OS_DATA = 0; WB_REQ = 0; WB_WE = 0;
        WB_ADDR = 0; WB_DATA = 0; WB_LAST = 0; HOST_RE = 0; HOST_ADDR = 0;
        step(); step();
        RST = 1'b0;
        for (int i = 0; i <= I_WD; i++) exp_st(0, i, (i == I_IDLE) ? 1 : 0);
        repeat (3) step();

        // Clear sweep: busy k+1..k+16, writes 0..15 in k+2..k+17
        CLR_REQ = 1;
        exp_st(1, I_CLR, 1); exp_st(16, I_CLR, 1); exp_st(17, I_CLR, 0);
        exp_st(1, I_WE, 0); exp_st(2, I_WE, 1); exp_st(17, I_WE, 1); exp_st(18, I_WE, 0);
        exp_st(17, I_ADDR, 15); exp_st(1, I_IDLE, 0); exp_st(18, I_IDLE, 1);
        exp_sweep(15);
        step(); CLR_REQ = 0;
        repeat (18) step();

        // Four back-to-back OutputStage writes
        exp_st(1, I_WE, 0); exp_st(2, I_WE, 1); exp_st(5, I_WE, 1); exp_st(6, I_WE, 0); exp_st(6, I_OVF, 0);
        for (int i = 0; i < 4; i++) begin
            OS_WE = 1; OS_ADDR = 4'(i); OS_DATA = DW'('hA0 + i);
            exp_wr(i, 'hA0 + i);
            step();
        end
        OS_WE = 0;
        repeat (6) step();

        // WB burst of 4 with 5 OS writes buffered behind it
        exp_st(0, I_WBG, 0); exp_st(1, I_WBG, 1); exp_st(4, I_WBG, 1); exp_st(5, I_WBG, 0);
        exp_st(2, I_SRC, 1); exp_st(5, I_SRC, 0); exp_st(10, I_WE, 1); exp_st(11, I_WE, 0); exp_st(11, I_OVF, 0);
        for (int i = 0; i < 4; i++) exp_wr(4 + i, 'hD4 + i);
        for (int i = 0; i < 5; i++) exp_wr(8 + i, 'hE0 + i);
        WB_REQ = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            WB_WE = 1; WB_ADDR = 4'(4 + i); WB_DATA = DW'('hD4 + i); WB_LAST = (i == 3);
            OS_WE = 1; OS_ADDR = 4'(8 + i); OS_DATA = DW'('hE0 + i);
            step();
        end
        WB_REQ = 0; WB_WE = 0; WB_LAST = 0; OS_ADDR = 12; OS_DATA = DW'('hE4);
        step(); OS_WE = 0;
        repeat (7) step();

        // Continuous OS writes with a starving WB request and a long burst
        exp_st(10, I_WBG, 0); exp_st(11, I_WBG, 1); exp_st(20, I_WBG, 1); exp_st(21, I_WBG, 0);
        exp_st(11, I_WE, 0); exp_st(12, I_WE, 1); exp_st(29, I_WE, 1); exp_st(30, I_WE, 0);
        exp_st(17, I_OVF, 0); exp_st(18, I_OVF, 1); exp_st(30, I_OVF, 1);
        for (int i = 0; i < 9; i++) exp_wr(i, 'h100 + i);
        for (int c = 11; c <= 20; c++) exp_wr(c - 11, 'h200 + c);
        for (int i = 9; i < 17; i++) exp_wr(i, 'h100 + i);
        for (int c = 0; c < 22; c++) begin
            OS_WE = c < 20; OS_ADDR = 4'(c); OS_DATA = DW'('h100 + c);
            WB_REQ = c >= 2 && c <= 20; WB_WE = c >= 11 && c <= 20;
            WB_ADDR = 4'(c - 11); WB_DATA = DW'('h200 + c); WB_LAST = c == 20;
            step();
        end
        OS_WE = 0; WB_REQ = 0; WB_WE = 0; WB_LAST = 0;
        repeat (9) step();
        CLR_REQ = 1;
        exp_st(0, I_OVF, 1); exp_st(1, I_OVF, 0);
        exp_sweep(15);
        step(); CLR_REQ = 0;
        repeat (18) step();

        // Host read waits behind two buffered writes
        exp_st(1, I_HG, 0); exp_st(2, I_HG, 0); exp_st(3, I_HG, 1); exp_st(4, I_HG, 0);
        exp_st(4, I_RE, 1); exp_st(4, I_RV, 0); exp_st(5, I_RV, 1); exp_st(5, I_RD, 'h55);
        exp_wr(3, 'h33); exp_wr(9, 'h55);
        om_q.push_back('{1'b1, 4'd9, '0});
        rd_q.push_back(DW'('h55));
        OS_WE = 1; OS_ADDR = 3; OS_DATA = DW'('h33);
        step();
        OS_ADDR = 9; OS_DATA = DW'('h55); HOST_RE = 1; HOST_ADDR = 9;
        step(); OS_WE = 0;
        step(); step(); HOST_RE = 0;
        repeat (4) step();

        // Reset mid-sweep while address 6 is on the bus, then a fresh sweep
        exp_st(8, I_CLR, 1); exp_st(8, I_WE, 1); exp_st(8, I_ADDR, 6);
        exp_st(9, I_WE, 0); exp_st(9, I_CLR, 0); exp_st(9, I_IDLE, 1); exp_st(9, I_WBG, 0);
        exp_st(9, I_OVF, 0); exp_st(9, I_RV, 0); exp_st(9, I_ADDR, 0); exp_st(9, I_WD, 0);
        exp_st(11, I_CLR, 1); exp_st(12, I_WE, 1); exp_st(12, I_ADDR, 0);
        exp_sweep(6);
        exp_sweep(15);
        CLR_REQ = 1;
        step(); CLR_REQ = 0;
        step(); OS_WE = 1; OS_ADDR = 2; OS_DATA = DW'('h77);
        step(); OS_WE = 0;
        repeat (5) step();
        RST = 1;
        step(); RST = 0;
        step(); CLR_REQ = 1;
        step(); CLR_REQ = 0;
        repeat (18) step();
        done = 1'b1;
    end
endmodule
